// File: rtl/axi_lite_regfile_sub.sv
// AXI4-Lite subordinate terminating req/resp structs into a word-addressed register file.
// Optional build macro AXI_LITE_REGFILE_DECERR_EN: full address decode with DECERR on out-of-range words.

package axi_lite_regfile_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = DataWidth / 8;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [2:0]           prot;
    } aw_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
    } w_chan_t;

    typedef struct packed {
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [2:0]           prot;
    } ar_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     w_ready;
        b_chan_t  b;
        logic     b_valid;
        logic     ar_ready;
        r_chan_t  r;
        logic     r_valid;
    } resp_t;

endpackage

module axi_lite_regfile_sub #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NumWords  = 16,
    parameter type         req_t     = axi_lite_regfile_pkg::req_t,
    parameter type         resp_t    = axi_lite_regfile_pkg::resp_t
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  req_t                          axi_req_i,
    output resp_t                         axi_resp_o,
    output logic [NumWords*DataWidth-1:0] regs_o
);

    localparam int unsigned StrbW   = DataWidth / 8;
    localparam int unsigned OffW    = $clog2(StrbW);
    localparam int unsigned IdxW    = $clog2(NumWords);
    localparam int unsigned IdxTopW = OffW + IdxW;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    logic [NumWords-1:0][DataWidth-1:0] regs_q, regs_d;

    logic [AddrWidth-1:0] aw_addr_q, aw_addr_d;
    logic [DataWidth-1:0] w_data_q, w_data_d;
    logic [StrbW-1:0]     w_strb_q, w_strb_d;

    logic                 aw_ready_q, aw_ready_d;
    logic                 w_ready_q, w_ready_d;
    logic                 b_valid_q, b_valid_d;
    logic [1:0]           b_resp_q, b_resp_d;
    logic                 ar_ready_q, ar_ready_d;
    logic                 r_valid_q, r_valid_d;
    logic [1:0]           r_resp_q, r_resp_d;
    logic [DataWidth-1:0] r_data_q, r_data_d;

    logic                 aw_hs_c, w_hs_c, ar_hs_c;
    logic                 do_write_c;
    logic [AddrWidth-1:0] wr_addr_c, rd_addr_c;
    logic [DataWidth-1:0] wr_data_c;
    logic [StrbW-1:0]     wr_strb_c;
    logic [IdxW-1:0]      wr_idx_c, rd_idx_c;
    logic                 wr_err_c, rd_err_c;
    logic                 unused_bits_c;

    assign aw_hs_c   = axi_req_i.aw_valid & aw_ready_q;
    assign w_hs_c    = axi_req_i.w_valid & w_ready_q;
    assign ar_hs_c   = axi_req_i.ar_valid & ar_ready_q;
    assign rd_addr_c = axi_req_i.ar.addr;

    assign wr_idx_c = wr_addr_c[OffW +: IdxW];
    assign rd_idx_c = rd_addr_c[OffW +: IdxW];

    // Out-of-range decode only exists in the DECERR build; otherwise addresses alias.
`ifdef AXI_LITE_REGFILE_DECERR_EN
    assign wr_err_c = |(wr_addr_c >> IdxTopW);
    assign rd_err_c = |(rd_addr_c >> IdxTopW);
`else
    assign wr_err_c = 1'b0;
    assign rd_err_c = 1'b0;
`endif

    assign unused_bits_c = ^{axi_req_i, wr_addr_c, rd_addr_c};

    // Write path next-state, beat capture and response generation.
    always_comb begin
        w_state_d  = w_state_q;
        aw_addr_d  = aw_addr_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        b_resp_d   = b_resp_q;
        do_write_c = 1'b0;
        wr_addr_c  = aw_addr_q;
        wr_data_c  = w_data_q;
        wr_strb_c  = w_strb_q;

        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs_c && w_hs_c) begin
                    do_write_c = 1'b1;
                    wr_addr_c  = axi_req_i.aw.addr;
                    wr_data_c  = axi_req_i.w.data;
                    wr_strb_c  = axi_req_i.w.strb;
                    w_state_d  = W_RESP;
                end else if (aw_hs_c) begin
                    aw_addr_d = axi_req_i.aw.addr;
                    w_state_d = W_HAVE_AW;
                end else if (w_hs_c) begin
                    w_data_d  = axi_req_i.w.data;
                    w_strb_d  = axi_req_i.w.strb;
                    w_state_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (w_hs_c) begin
                    do_write_c = 1'b1;
                    wr_data_c  = axi_req_i.w.data;
                    wr_strb_c  = axi_req_i.w.strb;
                    w_state_d  = W_RESP;
                end
            end
            W_HAVE_W: begin
                if (aw_hs_c) begin
                    do_write_c = 1'b1;
                    wr_addr_c  = axi_req_i.aw.addr;
                    w_state_d  = W_RESP;
                end
            end
            W_RESP: begin
                if (axi_req_i.b_ready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        if (do_write_c) begin
            b_resp_d = wr_err_c ? RespDecErr : RespOkay;
        end

        aw_ready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_W);
        w_ready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_AW);
        b_valid_d  = (w_state_d == W_RESP);
    end

    // Byte-lane merge into the addressed word.
    always_comb begin
        regs_d = regs_q;
        if (do_write_c && !wr_err_c) begin
            for (int k = 0; k < StrbW; k++) begin
                if (wr_strb_c[k]) begin
                    regs_d[wr_idx_c][8*k +: 8] = wr_data_c[8*k +: 8];
                end
            end
        end
    end

    // Read path: data sampled from the pre-write register state (read-before-write).
    always_comb begin
        r_state_d = r_state_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;

        unique case (r_state_q)
            R_IDLE: begin
                if (ar_hs_c) begin
                    r_data_d  = rd_err_c ? '0 : regs_q[rd_idx_c];
                    r_resp_d  = rd_err_c ? RespDecErr : RespOkay;
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (axi_req_i.r_ready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        ar_ready_d = (r_state_d == R_IDLE);
        r_valid_d  = (r_state_d == R_RESP);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            regs_q     <= '0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b1;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RespOkay;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_resp_q   <= RespOkay;
            r_data_q   <= '0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            regs_q     <= regs_d;
            aw_addr_q  <= aw_addr_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            b_resp_q   <= b_resp_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_resp_q   <= r_resp_d;
            r_data_q   <= r_data_d;
        end
    end

    // Response bundle is a pure view of flops; unused fields stay zero.
    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = aw_ready_q;
        axi_resp_o.w_ready  = w_ready_q;
        axi_resp_o.b.resp   = b_resp_q;
        axi_resp_o.b_valid  = b_valid_q;
        axi_resp_o.ar_ready = ar_ready_q;
        axi_resp_o.r.data   = r_data_q;
        axi_resp_o.r.resp   = r_resp_q;
        axi_resp_o.r_valid  = r_valid_q;
    end

    assign regs_o = regs_q;

endmodule

// File: tb/tb_axi_lite_regfile_sub.sv
// Directed self-checking bench for axi_lite_regfile_sub (default 32-bit, 16-word build).

module tb_axi_lite_regfile_sub;

    import axi_lite_regfile_pkg::*;

    localparam int unsigned NW = 16;
    localparam int unsigned DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    req_t            req;
    resp_t           resp;
    logic [NW*DW-1:0] regs;

    int errors = 0;
    int checks = 0;

    axi_lite_regfile_sub #(
        .AddrWidth(32),
        .DataWidth(DW),
        .NumWords (NW)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .axi_req_i (req),
        .axi_resp_o(resp),
        .regs_o    (regs)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input int i);
        return regs[i*DW +: DW];
    endfunction

    // Same-cycle AW+W, then B handshake.
    task automatic write_full(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        req.aw.addr  = addr;
        req.aw_valid = 1'b1;
        req.w.data   = data;
        req.w.strb   = strb;
        req.w_valid  = 1'b1;
        tick();
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        req.b_ready  = 1'b1;
        tick();
        req.b_ready  = 1'b0;
    endtask

    task automatic read_word(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] rsp);
        req.ar.addr  = addr;
        req.ar_valid = 1'b1;
        tick();
        req.ar_valid = 1'b0;
        data = resp.r.data;
        rsp  = resp.r.resp;
        req.r_ready = 1'b1;
        tick();
        req.r_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic [1:0]  rr;

    initial begin
        req = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_aw_ready", resp.aw_ready, 1);
        check("rst_w_ready", resp.w_ready, 1);
        check("rst_ar_ready", resp.ar_ready, 1);
        check("rst_b_valid", resp.b_valid, 0);
        check("rst_r_valid", resp.r_valid, 0);
        check("rst_r_data", resp.r.data, 0);
        check("rst_regs_zero", 64'(regs == '0), 1);

        // 1: same-cycle AW+W to 0x04
        req.aw.addr = 32'h04; req.aw_valid = 1'b1;
        req.w.data = 32'hDEADBEEF; req.w.strb = 4'hF; req.w_valid = 1'b1;
        tick();
        req.aw_valid = 1'b0; req.w_valid = 1'b0;
        check("t1_b_valid", resp.b_valid, 1);
        check("t1_b_resp", resp.b.resp, 0);
        check("t1_word1", word(1), 32'hDEADBEEF);
        check("t1_aw_ready_busy", resp.aw_ready, 0);
        req.b_ready = 1'b1;
        tick();
        req.b_ready = 1'b0;
        check("t1_b_done", resp.b_valid, 0);
        check("t1_aw_ready_back", resp.aw_ready, 1);
        req.ar.addr = 32'h04; req.ar_valid = 1'b1;
        tick();
        req.ar_valid = 1'b0;
        check("t1_r_valid", resp.r_valid, 1);
        check("t1_r_data", resp.r.data, 32'hDEADBEEF);
        check("t1_ar_ready_busy", resp.ar_ready, 0);
        req.r_ready = 1'b1;
        tick();
        req.r_ready = 1'b0;
        check("t1_r_done", resp.r_valid, 0);
        check("t1_ar_ready_back", resp.ar_ready, 1);

        // strb=0 leaves word untouched and returns OKAY
        req.aw.addr = 32'h04; req.aw_valid = 1'b1;
        req.w.data = 32'h0; req.w.strb = 4'h0; req.w_valid = 1'b1;
        tick();
        req.aw_valid = 1'b0; req.w_valid = 1'b0;
        check("strb0_resp", resp.b.resp, 0);
        check("strb0_word1", word(1), 32'hDEADBEEF);
        req.b_ready = 1'b1; tick(); req.b_ready = 1'b0;

        // 2: W leads AW by 3 cycles, partial strobe over preloaded word
        write_full(32'h08, 32'hFFFFFFFF, 4'hF);
        check("t2_preload", word(2), 32'hFFFFFFFF);
        req.w.data = 32'h11223344; req.w.strb = 4'h5; req.w_valid = 1'b1;
        tick();
        req.w_valid = 1'b0;
        check("t2_w_ready_held", resp.w_ready, 0);
        check("t2_aw_ready_open", resp.aw_ready, 1);
        tick();
        tick();
        check("t2_no_early_write", word(2), 32'hFFFFFFFF);
        check("t2_no_early_b", resp.b_valid, 0);
        req.aw.addr = 32'h08; req.aw_valid = 1'b1;
        tick();
        req.aw_valid = 1'b0;
        check("t2_b_valid", resp.b_valid, 1);
        check("t2_word2", word(2), 32'hFF22FF44);
        req.b_ready = 1'b1; tick(); req.b_ready = 1'b0;

        // 3: B back-pressure for 5 cycles, then back-to-back AW
        req.aw.addr = 32'h14; req.aw_valid = 1'b1;
        req.w.data = 32'h12345678; req.w.strb = 4'hF; req.w_valid = 1'b1;
        tick();
        req.aw_valid = 1'b0; req.w_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t3_b_hold_valid", resp.b_valid, 1);
            check("t3_b_hold_resp", resp.b.resp, 0);
            check("t3_b_hold_aw_ready", resp.aw_ready, 0);
            check("t3_b_hold_w_ready", resp.w_ready, 0);
            tick();
        end
        req.b_ready = 1'b1;
        tick();
        req.b_ready = 1'b0;
        check("t3_aw_ready_after_b", resp.aw_ready, 1);
        req.aw.addr = 32'h18; req.aw_valid = 1'b1;
        tick();
        req.aw_valid = 1'b0;
        check("t3_aw_taken", resp.aw_ready, 0);
        check("t3_w_wait", resp.w_ready, 1);
        req.w.data = 32'h0BADF00D; req.w.strb = 4'hF; req.w_valid = 1'b1;
        tick();
        req.w_valid = 1'b0;
        check("t3_b2_valid", resp.b_valid, 1);
        check("t3_word5", word(5), 32'h12345678);
        check("t3_word6", word(6), 32'h0BADF00D);
        req.b_ready = 1'b1; tick(); req.b_ready = 1'b0;

        // 4: read-before-write on word3
        req.aw.addr = 32'h0C; req.aw_valid = 1'b1;
        req.w.data = 32'hA5A5A5A5; req.w.strb = 4'hF; req.w_valid = 1'b1;
        req.ar.addr = 32'h0C; req.ar_valid = 1'b1;
        tick();
        req.aw_valid = 1'b0; req.w_valid = 1'b0; req.ar_valid = 1'b0;
        check("t4_r_old", resp.r.data, 0);
        check("t4_word3_new", word(3), 32'hA5A5A5A5);
        req.b_ready = 1'b1; req.r_ready = 1'b1;
        tick();
        req.b_ready = 1'b0; req.r_ready = 1'b0;
        read_word(32'h0C, rd, rr);
        check("t4_r_new", rd, 32'hA5A5A5A5);

        // 5: reset while W_HAVE_AW and R_RESP
        req.aw.addr = 32'h1C; req.aw_valid = 1'b1;
        req.ar.addr = 32'h04; req.ar_valid = 1'b1;
        tick();
        req.aw_valid = 1'b0; req.ar_valid = 1'b0;
        check("t5_pre_aw_ready", resp.aw_ready, 0);
        check("t5_pre_r_valid", resp.r_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_b_valid", resp.b_valid, 0);
        check("t5_r_valid", resp.r_valid, 0);
        check("t5_aw_ready", resp.aw_ready, 1);
        check("t5_w_ready", resp.w_ready, 1);
        check("t5_ar_ready", resp.ar_ready, 1);
        check("t5_r_data", resp.r.data, 0);
        check("t5_regs_zero", 64'(regs == '0), 1);
        req.w.data = 32'hFFFFFFFF; req.w.strb = 4'hF; req.w_valid = 1'b1;
        tick();
        req.w_valid = 1'b0;
        check("t5_no_stale_b", resp.b_valid, 0);
        check("t5_word7_untouched", word(7), 0);
        req.aw.addr = 32'h20; req.aw_valid = 1'b1;
        tick();
        req.aw_valid = 1'b0;
        check("t5_word8", word(8), 32'hFFFFFFFF);
        check("t5_word7_still", word(7), 0);
        req.b_ready = 1'b1; tick(); req.b_ready = 1'b0;

        // 6: address 0x40 (word index 16)
        req.aw.addr = 32'h40; req.aw_valid = 1'b1;
        req.w.data = 32'hCAFEF00D; req.w.strb = 4'hF; req.w_valid = 1'b1;
        tick();
        req.aw_valid = 1'b0; req.w_valid = 1'b0;
`ifdef AXI_LITE_REGFILE_DECERR_EN
        check("t6_b_resp", resp.b.resp, 2'b11);
        check("t6_word0", word(0), 0);
`else
        check("t6_b_resp", resp.b.resp, 2'b00);
        check("t6_word0", word(0), 32'hCAFEF00D);
`endif
        req.b_ready = 1'b1; tick(); req.b_ready = 1'b0;
        read_word(32'h40, rd, rr);
`ifdef AXI_LITE_REGFILE_DECERR_EN
        check("t6_r_data", rd, 0);
        check("t6_r_resp", rr, 2'b11);
`else
        check("t6_r_data", rd, 32'hCAFEF00D);
        check("t6_r_resp", rr, 2'b00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
